// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register stage with skid buffer:
// occupancy-state encoding and default bundle/counter widths.
package pipe_pkg;

    localparam int unsigned CTRL_W_DEF = 4;   // RegWrite, MemtoReg, MemRead, MemWrite
    localparam int unsigned DATA_W_DEF = 69;  // ALU result 32, write data 32, rd 5
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk_i) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with a one-entry skid buffer, flush-to-bubble and
// a saturating count of cycles where the output was stalled.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    pipe_state_e       state_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              accept;
    logic              consume;

    // Ready comes only from registered occupancy, never from out_ready_i.
    assign in_ready_o = (state_q != ST_SKID) && !rst_i;
    assign accept     = in_valid_i && in_ready_o;
    assign consume    = out_valid_o && out_ready_i;

    // The main register drives the outputs directly; its ctrl field is
    // zeroed whenever it empties so a bubble never carries write enables.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            out_valid_o <= 1'b0;
            out_ctrl_o  <= '0;
            out_data_o  <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (flush_i) begin
            state_q     <= ST_EMPTY;
            out_valid_o <= 1'b0;
            out_ctrl_o  <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q     <= ST_FULL;
                        out_valid_o <= 1'b1;
                        out_ctrl_o  <= in_ctrl_i;
                        out_data_o  <= in_data_i;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        if (accept) begin
                            out_ctrl_o <= in_ctrl_i;
                            out_data_o <= in_data_i;
                        end else begin
                            state_q     <= ST_EMPTY;
                            out_valid_o <= 1'b0;
                            out_ctrl_o  <= '0;
                        end
                    end else if (accept) begin
                        state_q     <= ST_SKID;
                        skid_ctrl_q <= in_ctrl_i;
                        skid_data_q <= in_data_i;
                    end
                end
                ST_SKID: begin
                    if (consume) begin
                        state_q    <= ST_FULL;
                        out_ctrl_o <= skid_ctrl_q;
                        out_data_o <= skid_data_q;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_o <= 1'b0;
                    out_ctrl_o  <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .inc   (out_valid_o && !out_ready_i),
        .clr   (rst_i),
        .cnt   (stall_cnt_o)
    );

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter CTRL_W, default 4, SHALL set control-bundle width (RegWrite, MemtoReg, MemRead, MemWrite).
REQ-002 Parameter DATA_W, default 69, SHALL set data-bundle width (ALU result 32, write data 32, rd 5).
REQ-003 Parameter CNT_W, default 16, SHALL set stall-counter width.
REQ-004 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  SHALL be the reset: synchronous and active-high.
REQ-006 flush_i  in  1  SHALL discard all held entries (bubble insertion).
REQ-007 in_valid_i  in  1  SHALL mark in_ctrl_i/in_data_i as valid upstream.
REQ-008 in_ready_o  out  1  SHALL show that the stage accepts an entry this cycle.
REQ-009 in_ctrl_i  in  CTRL_W  and  in_data_i  in  DATA_W  SHALL carry the upstream entry.
REQ-010 out_valid_o  out  1  SHALL mark out_ctrl_o/out_data_o as valid.
REQ-011 out_ready_i  in  1  SHALL show that downstream consumes this cycle.
REQ-012 out_ctrl_o  out  CTRL_W  and  out_data_o  out  DATA_W  SHALL carry the head entry.
REQ-013 stall_cnt_o  out  CNT_W  SHALL give the saturating count of output-stall cycles.

Function
REQ-014 Transfers SHALL occur only on valid&ready, on either side; entries leave in arrival order, with no loss or duplication.
REQ-015 Storage SHALL be a main register plus one skid register; states EMPTY (none), FULL (main), SKID (main+skid).
REQ-016 in_ready_o SHALL equal !skid_valid && !rst_i and SHALL depend only on registered state and rst_i, with no combinational path from out_ready_i.
REQ-017 EMPTY with accept SHALL load main -> FULL; latency input-to-output SHALL be exactly 1 cycle.
REQ-018 FULL with accept and out_ready_i SHALL replace main with the new entry, staying FULL.
REQ-019 FULL with out_ready_i and no accept SHALL go -> EMPTY.
REQ-020 FULL with accept and !out_ready_i SHALL load skid -> SKID.
REQ-021 SKID with out_ready_i SHALL move skid into main -> FULL; SKID with !out_ready_i SHALL hold.
REQ-022 out_ctrl_o SHALL be all-zero whenever out_valid_o is 0, so a bubble never asserts RegWrite or MemWrite.
REQ-023 out_data_o SHALL hold its last value when invalid and need not be zeroed.
REQ-024 flush_i SHALL have priority over every transfer: next state EMPTY, any same-cycle input dropped, any same-cycle output still counted as consumed by downstream.
REQ-025 stall_cnt_o SHALL increment by 1 each cycle with out_valid_o && !out_ready_i, saturate at 2^CNT_W-1, and not be cleared by flush_i.

Reset
REQ-026 While rst_i is high, the next state SHALL be EMPTY and stall_cnt_o SHALL become 0.
REQ-027 While rst_i is high, in_ready_o SHALL be 0 and input SHALL be ignored.
REQ-028 After reset, out_valid_o=0, out_ctrl_o=0, out_data_o=0 and stall_cnt_o=0 SHALL hold until new activity.
REQ-029 Reset asserted mid-stall, in SKID, SHALL discard both entries in that cycle.
REQ-030 rst_i SHALL take priority over flush_i.

Structure
REQ-031 The state encoding (EMPTY/FULL/SKID) and the default widths SHALL live in shared package pipe_pkg.
REQ-032 The stall counter SHALL be the sub-module sat_counter (parameter W; inputs inc, clr), instantiated once.
REQ-033 No memories and no latches SHALL be used; all outputs SHALL be registered except in_ready_o.

Verification
REQ-034 Reset, then send ctrl=4'b1010, data=69'h5 with out_ready_i=1 -> out_valid_o=1, out_ctrl_o=4'b1010 one cycle later; in_ready_o stays 1.
REQ-035 out_ready_i=0, send A then B -> state SKID, in_ready_o=0; raise out_ready_i -> A then B emerge in consecutive cycles, and C is not accepted until in_ready_o returns to 1.
REQ-036 flush_i pulse in SKID with in_valid_i=1 -> next cycle out_valid_o=0, out_ctrl_o=0, in_ready_o=1; the flushed input never appears.
REQ-037 CNT_W=3, hold out_valid_o=1 with out_ready_i=0 for 10 cycles -> stall_cnt_o ends at 7 and stays 7.
REQ-038 rst_i in SKID with in_valid_i=1 -> in_ready_o=0 during reset; after reset out_valid_o=0 and stall_cnt_o=0.
REQ-039 Random valid/ready traffic over 10k cycles with a scoreboard -> output sequence identical to the accepted-input sequence, excluding flushed entries.
